opponent_control: RTL
=====================

OPPONENT_CONTROL -- requirements
Module: opponent_control

Interface
REQ-001 SHALL have parameter START_HEALTH, default 4'd15, reset value of both health counters.
REQ-002 SHALL have parameter IDLE_TICKS, default 16, ticks spent in IDLE before a wind-up.
REQ-003 SHALL have parameter WINDUP_TICKS, default 8, telegraph length in ticks.
REQ-004 SHALL have parameter RECOVER_TICKS, default 6, post-attack recovery in ticks.
REQ-005 SHALL have parameter STUN_TICKS, default 10, stun length in ticks.
REQ-006 SHALL have port clock, input, 1, sole clock, all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port tick, input, 1, single-cycle timing strobe that advances all tick counters.
REQ-009 SHALL have ports lpunch and rpunch, input, 1 each, the user's punch levels, held while the key is held.
REQ-010 SHALL have port can_be_hit, input, 1, high when the user is not blocking.
REQ-011 SHALL have port user_health, output, 4, the user's health; it drives the user FSM's health input.
REQ-012 SHALL have port opp_health, output, 4, the opponent's health.
REQ-013 SHALL have ports windup, punch_side, opp_lpunch, opp_rpunch, stunned, opp_ko and user_ko, output, 1 each, all registered.

Function
REQ-014 SHALL implement states IDLE, WINDUP, ATTACK, RECOVER, STUNNED, KO and WIN in a 3-bit register.
REQ-015 SHALL clear the tick counter on every state entry and transition on the cycle where tick=1 and the count equals N-1.
REQ-016 SHALL register the previous lpunch and rpunch values; a rising edge on either input is a user hit, and edges on both in the same cycle count as one hit.
REQ-017 IDLE: go to WINDUP after IDLE_TICKS; on WINDUP entry, punch_side SHALL toggle (first attack after reset is right, side=1).
REQ-018 WINDUP: windup=1; go to ATTACK after WINDUP_TICKS; a user hit here SHALL deal 2 damage and go to STUNNED (counter-punch).
REQ-019 ATTACK: lasts exactly 1 cycle; opp_lpunch or opp_rpunch=1 per punch_side.
REQ-020 In ATTACK, if can_be_hit=1, user_health SHALL decrement by 1; if can_be_hit=0, user_health is unchanged.
REQ-021 In ATTACK, user hits SHALL be ignored; the next state is always RECOVER.
REQ-022 Damage from user hits: IDLE deals 1; RECOVER and STUNNED deal 2; RECOVER goes to IDLE after RECOVER_TICKS; STUNNED goes to IDLE after STUN_TICKS, with stunned=1 while in STUNNED.
REQ-023 Health subtraction SHALL saturate at 0 (damage 2 from health 1 leaves 0); health never wraps.
REQ-024 When opp_health would become 0, the next state SHALL be KO, overriding any other transition.
REQ-025 When user_health would become 0, the next state SHALL be WIN.
REQ-026 KO and WIN SHALL be absorbing until reset; opp_ko=1 in KO, user_ko=1 in WIN, and user hits are ignored in both.
REQ-027 All punch, windup and stunned outputs SHALL be 0 outside their defining state.

Reset
REQ-028 On reset=1 at a clock edge, the state SHALL be IDLE, counter 0, punch_side 0, edge registers 0, and both healths START_HEALTH.
REQ-029 During reset, all single-bit outputs SHALL read 0; reset SHALL take priority over tick, hits and a mid-WINDUP or mid-STUN state.
REQ-030 Edge registers SHALL reload from the inputs on the first cycle after reset, so a punch held through reset is not a hit.

Structure
REQ-031 State encodings and the damage constants (1 and 2) SHALL live in the shared punchout package.
REQ-032 The tick-counter-with-clear SHALL be one sub-module, tick_timer, with inputs clock, reset, clear, tick and limit, and output done.

Verification
REQ-033 Bench uses IDLE=2, WINDUP=2, RECOVER=2, STUN=3 and tick every cycle; reset then no input -> windup=1 on cycles 3-4, opp_rpunch=1 on cycle 5, user_health 15->14.
REQ-034 Same run with can_be_hit=0 in cycle 5 -> opp_rpunch=1 and user_health stays 15; the next attack is on the left.
REQ-035 rpunch rising edge during WINDUP -> opp_health 15->13, stunned=1 for 3 cycles, and no ATTACK occurs.
REQ-036 lpunch and rpunch rise together in IDLE -> opp_health drops by 1 only; holding rpunch high -> no further damage.
REQ-037 opp_health=1 with a hit in RECOVER -> opp_health=0 (no wrap), opp_ko=1, and it stays in KO despite more ticks and hits.
REQ-038 Reset asserted mid-STUNNED with lpunch held -> IDLE, healths at 15, and no hit counted on release of reset.

Source files
------------

// File: rtl/punchout_pkg.sv
// rtl/punchout_pkg.sv - shared opponent state encodings, damage constants and health helper
package punchout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WINDUP  = 3'd1,
        ST_ATTACK  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_STUNNED = 3'd4,
        ST_KO      = 3'd5,
        ST_WIN     = 3'd6
    } opp_state_e;

    localparam logic [3:0] DMG_LIGHT = 4'd1;
    localparam logic [3:0] DMG_HEAVY = 4'd2;
    localparam int         CNT_W     = 8;

    // Health never wraps: any damage at or above the remaining health lands on zero.
    function automatic logic [3:0] sat_sub(input logic [3:0] health, input logic [3:0] dmg);
        return (dmg >= health) ? 4'd0 : health - dmg;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - tick-strobe counter with clear; done flags the last tick of a phase
module tick_timer
    import punchout_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = tick && (cnt_q == limit - CNT_W'(1));

endmodule

// File: rtl/opponent_control.sv
// rtl/opponent_control.sv - opponent boxer FSM: telegraphed attacks, counter-punch stuns, health and KO/WIN
module opponent_control
    import punchout_pkg::*;
#(
    parameter logic [3:0] START_HEALTH  = 4'd15,
    parameter int         IDLE_TICKS    = 16,
    parameter int         WINDUP_TICKS  = 8,
    parameter int         RECOVER_TICKS = 6,
    parameter int         STUN_TICKS    = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       lpunch,
    input  logic       rpunch,
    input  logic       can_be_hit,
    output logic [3:0] user_health,
    output logic [3:0] opp_health,
    output logic       windup,
    output logic       punch_side,
    output logic       opp_lpunch,
    output logic       opp_rpunch,
    output logic       stunned,
    output logic       opp_ko,
    output logic       user_ko
);

    opp_state_e       state_q, state_d;
    logic [3:0]       user_hp_q, user_hp_d, opp_hp_q, opp_hp_d;
    logic [3:0]       opp_dmg, user_dmg;
    logic             side_q, side_d;
    logic             prev_l_q, prev_r_q, armed_q;
    logic             windup_q, opp_l_q, opp_r_q, stunned_q, opp_ko_q, user_ko_q;
    logic [CNT_W-1:0] limit;
    logic             timer_clear, timer_done, user_hit;

    always_comb begin
        case (state_q)
            ST_IDLE:    limit = CNT_W'(IDLE_TICKS);
            ST_WINDUP:  limit = CNT_W'(WINDUP_TICKS);
            ST_RECOVER: limit = CNT_W'(RECOVER_TICKS);
            ST_STUNNED: limit = CNT_W'(STUN_TICKS);
            default:    limit = CNT_W'(1);
        endcase
    end

    assign timer_clear = (state_d != state_q);

    tick_timer u_timer (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick),
        .limit (limit),
        .done  (timer_done)
    );

    // armed_q masks the first cycle after reset so a key held through reset is not a hit.
    assign user_hit = armed_q && ((lpunch && !prev_l_q) || (rpunch && !prev_r_q));

    always_comb begin
        state_d  = state_q;
        opp_dmg  = '0;
        user_dmg = '0;
        case (state_q)
            ST_IDLE: begin
                if (user_hit) opp_dmg = DMG_LIGHT;
                if (timer_done) state_d = ST_WINDUP;
            end
            ST_WINDUP: begin
                if (user_hit) begin
                    opp_dmg = DMG_HEAVY;
                    state_d = ST_STUNNED;
                end else if (timer_done) begin
                    state_d = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                if (can_be_hit) user_dmg = DMG_LIGHT;
                state_d = ST_RECOVER;
            end
            ST_RECOVER, ST_STUNNED: begin
                if (user_hit) opp_dmg = DMG_HEAVY;
                if (timer_done) state_d = ST_IDLE;
            end
            default: ;
        endcase
        opp_hp_d  = sat_sub(opp_hp_q, opp_dmg);
        user_hp_d = sat_sub(user_hp_q, user_dmg);
        if (user_dmg != '0 && user_hp_d == '0) state_d = ST_WIN;
        if (opp_dmg != '0 && opp_hp_d == '0) state_d = ST_KO;
        side_d = side_q ^ (state_d == ST_WINDUP && state_q != ST_WINDUP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            user_hp_q <= START_HEALTH;
            opp_hp_q  <= START_HEALTH;
            side_q    <= 1'b0;
            prev_l_q  <= 1'b0;
            prev_r_q  <= 1'b0;
            armed_q   <= 1'b0;
            windup_q  <= 1'b0;
            opp_l_q   <= 1'b0;
            opp_r_q   <= 1'b0;
            stunned_q <= 1'b0;
            opp_ko_q  <= 1'b0;
            user_ko_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            user_hp_q <= user_hp_d;
            opp_hp_q  <= opp_hp_d;
            side_q    <= side_d;
            prev_l_q  <= lpunch;
            prev_r_q  <= rpunch;
            armed_q   <= 1'b1;
            windup_q  <= (state_d == ST_WINDUP);
            opp_l_q   <= (state_d == ST_ATTACK) && !side_d;
            opp_r_q   <= (state_d == ST_ATTACK) && side_d;
            stunned_q <= (state_d == ST_STUNNED);
            opp_ko_q  <= (state_d == ST_KO);
            user_ko_q <= (state_d == ST_WIN);
        end
    end

    assign user_health = user_hp_q;
    assign opp_health  = opp_hp_q;
    assign windup      = windup_q;
    assign punch_side  = side_q;
    assign opp_lpunch  = opp_l_q;
    assign opp_rpunch  = opp_r_q;
    assign stunned     = stunned_q;
    assign opp_ko      = opp_ko_q;
    assign user_ko     = user_ko_q;

endmodule
